retire_rat: RTL
===============

# retire_rat

Retirement register alias table for the out-of-order RV32I core. It sits between ROB commit and the physical-register free list, and holds the committed architectural-to-physical mapping. On each commit it records the new mapping and queues the displaced physical register for return to the free list, one per cycle. It also exposes the full committed map so the front-end RAT can be restored on a branch flush.

## Interface
Parameters:
- ARCH_REGS, 32, number of architectural registers (x0..x31)
- PHYS_WIDTH, 6, physical register index width (64 physical regs)
- RET_BUF_DEPTH, 4, return-buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- commit0_valid  in  1  oldest committing instruction has a destination
- commit0_rd  in  5  its architectural rd
- commit0_pd  in  PHYS_WIDTH  its physical destination
- commit1_valid / commit1_rd / commit1_pd  in  1/5/PHYS_WIDTH  second (younger) commit slot; used only with RRF_DUAL_COMMIT_EN
- commit_ready  out  1  ROB may present commits this cycle
- free_enqueue  out  1  drives free-list enqueue
- free_pd  out  PHYS_WIDTH  drives free-list write data
- global_branch_signal  in  1  pipeline flush
- rrf_map  out  ARCH_REGS*PHYS_WIDTH  committed map; entry i at bits [i*PHYS_WIDTH +: PHYS_WIDTH]

## Operation
- Map table: ARCH_REGS × PHYS_WIDTH flops. On reset, table[i] = i. (Physical regs 32..63 start in the free list.)
- A commit is accepted when commitN_valid && commit_ready.
- Accepted commit with rd != 0:
  - push the old table[rd] into the return buffer;
  - write table[rd] = pd.
- Accepted commit with rd == 0: no table write, no push.
- Dual commit, same cycle: slot 0 is processed before slot 1.
  - If both target the same nonzero rd: push the old table[rd] first, then commit0_pd; table[rd] ends as commit1_pd.
  - Buffer order is always slot 0's push, then slot 1's push.
- Return buffer: circular FIFO with head, tail and count registers. 0–2 pushes and 0–1 pop per cycle.
  - free_enqueue = (count != 0). free_pd = buf[head]. Both come straight from flops.
  - A pop happens on every edge where free_enqueue is high. The free list always accepts: total in-flight registers cannot exceed 64.
- commit_ready:
  - dual mode: count ≤ RET_BUF_DEPTH−2;
  - single mode: count ≤ RET_BUF_DEPTH−1.
  - It is computed from the registered count only. The same-cycle pop is not credited.
- Commits presented while commit_ready is low are ignored. The table and buffer are unchanged.
- global_branch_signal:
  - Does not modify the table or the buffer.
  - Commits in the same cycle are older than the flush and are applied normally.
  - Buffered entries keep draining; none are dropped.
- rrf_map is the table register contents.

## Timing
- Reset values:
  - table[i] = i;
  - count = 0, head = 0, tail = 0;
  - free_enqueue = 0, free_pd = 0 (buffer storage cleared);
  - commit_ready = 1.
- rst has priority over any commit or pop in the same cycle. Reset mid-drain discards buffered entries.
- Commit accepted at edge N:
  - rrf_map reflects it during cycle N+1.
  - The pushed pd appears on free_pd with free_enqueue high in cycle N+1 if the buffer was empty. Otherwise it appears after the older entries drain, one per cycle.
- Push and pop at the same edge: count' = count + pushes − pop.
- head and tail wrap modulo RET_BUF_DEPTH.
- In dual mode, two pushes into a buffer at count = DEPTH−2 with a simultaneous pop give count' = DEPTH−1. commit_ready is then low for the next cycle.

## Configuration
- RRF_DUAL_COMMIT_EN defined:
  - commit slot 1 is active;
  - up to 2 pushes per cycle;
  - commit_ready threshold is DEPTH−2.
- Not defined:
  - commit1_* inputs are ignored (treated as invalid);
  - one push per cycle;
  - commit_ready threshold is DEPTH−1.
  - The table, buffer and drain behaviour are otherwise identical.

## Test plan
- Reset → rrf_map entry 5 = 5, free_enqueue = 0, commit_ready = 1. Commit rd=5, pd=40 at edge N → in cycle N+1, free_enqueue = 1, free_pd = 5, entry 5 = 40. In cycle N+2, free_enqueue = 0.
- Commit rd=0, pd=0 → no table change, free_enqueue stays 0.
- Dual (macro on), same edge: slot0 rd=3 pd=33 and slot1 rd=3 pd=34 → free_pd = 3, then 33 on consecutive cycles; entry 3 = 34.
- Dual, distinct rd every cycle (rd=1..4, pd=41..44) → commit_ready drops after the buffer reaches count ≥ 3. Commits presented while ready is low leave the map unchanged. Drain order is 1, 2, 3, 4 with no loss across head/tail wrap.
- global_branch_signal with commit rd=7 pd=50 and 2 entries buffered → entry 7 = 50; all 3 returns emerge on the next 3 cycles.
- rst asserted while count = 3 → next cycle free_enqueue = 0, all entries identity, commit_ready = 1.

Source files
------------

// File: rtl/retire_rat.sv
// retire_rat: retirement register alias table.
// Holds the committed architectural-to-physical map. On each commit it
// queues the displaced physical register in a small return FIFO, which
// drains one entry per cycle into the free list. The full committed map
// is exported so the front-end RAT can be restored after a flush.
// Optional feature: define RRF_DUAL_COMMIT_EN to enable the second commit
// slot, which allows up to two buffer pushes per cycle.
module retire_rat #(
  parameter int ARCH_REGS     = 32,
  parameter int PHYS_WIDTH    = 6,
  parameter int RET_BUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            commit0_valid,
  input  logic [4:0]                      commit0_rd,
  input  logic [PHYS_WIDTH-1:0]           commit0_pd,
  input  logic                            commit1_valid,
  input  logic [4:0]                      commit1_rd,
  input  logic [PHYS_WIDTH-1:0]           commit1_pd,
  output logic                            commit_ready,
  output logic                            free_enqueue,
  output logic [PHYS_WIDTH-1:0]           free_pd,
  input  logic                            global_branch_signal,
  output logic [ARCH_REGS*PHYS_WIDTH-1:0] rrf_map
);

  localparam int PTR_W = $clog2(RET_BUF_DEPTH);
  localparam int CNT_W = $clog2(RET_BUF_DEPTH + 1);

  logic slot1_valid;

`ifdef RRF_DUAL_COMMIT_EN
  // Two pushes may land in one cycle, so keep room for both.
  localparam int READY_MAX = RET_BUF_DEPTH - 2;
  assign slot1_valid = commit1_valid;
  // A flush only redirects the front end; committed state is untouched.
  logic unused_flush;
  assign unused_flush = global_branch_signal;
`else
  localparam int READY_MAX = RET_BUF_DEPTH - 1;
  assign slot1_valid = 1'b0;
  // Slot 1 is disabled; a flush leaves committed state untouched.
  logic unused_slot1;
  assign unused_slot1 = ^{commit1_valid, commit1_rd, commit1_pd, global_branch_signal};
`endif

  logic [PHYS_WIDTH-1:0] map_q  [ARCH_REGS];
  logic [PHYS_WIDTH-1:0] map_d  [ARCH_REGS];
  logic [PHYS_WIDTH-1:0] rbuf_q [RET_BUF_DEPTH];
  logic [PHYS_WIDTH-1:0] rbuf_d [RET_BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  acc0, acc1, pop;
  logic [PHYS_WIDTH-1:0] old0, old1;
  logic [PTR_W-1:0]      wptr;
  logic [1:0]            npush;

  // Ready comes from the registered count only; the same-cycle pop is not credited.
  assign commit_ready = (count_q <= CNT_W'(READY_MAX));
  assign free_enqueue = (count_q != '0);
  assign free_pd      = rbuf_q[head_q];

  // Export the committed table as a flat vector, entry i at [i*PHYS_WIDTH +: PHYS_WIDTH].
  for (genvar gi = 0; gi < ARCH_REGS; gi++) begin : g_map_out
    assign rrf_map[gi*PHYS_WIDTH +: PHYS_WIDTH] = map_q[gi];
  end

  // Apply accepted commits (slot 0 before slot 1) and update the return FIFO.
  always_comb begin
    map_d   = map_q;
    rbuf_d  = rbuf_q;
    acc0    = commit0_valid && commit_ready && (commit0_rd != 5'd0);
    acc1    = slot1_valid   && commit_ready && (commit1_rd != 5'd0);
    pop     = free_enqueue;
    npush   = 2'd0;
    wptr    = tail_q;

    old0 = map_q[commit0_rd];
    // Slot 1 sees slot 0's write when both target the same register.
    old1 = (acc0 && (commit1_rd == commit0_rd)) ? commit0_pd : map_q[commit1_rd];

    if (acc0) begin
      map_d[commit0_rd] = commit0_pd;
      rbuf_d[wptr]      = old0;
      wptr              = wptr + PTR_W'(1);
      npush             = npush + 2'd1;
    end
    if (acc1) begin
      map_d[commit1_rd] = commit1_pd;
      rbuf_d[wptr]      = old1;
      wptr              = wptr + PTR_W'(1);
      npush             = npush + 2'd1;
    end

    tail_d  = wptr;
    head_d  = pop ? (head_q + PTR_W'(1)) : head_q;
    count_d = count_q + CNT_W'(npush) - CNT_W'(pop);
  end

  // State registers; reset restores the identity map and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PHYS_WIDTH'(i);
      for (int j = 0; j < RET_BUF_DEPTH; j++) rbuf_q[j] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_d;
      rbuf_q  <= rbuf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
